recv_pc_to_ram32: RTL and testbench
===================================

Name: recv_pc_to_ram32

Overview:
UART-to-RAM loader, the PC→FPGA counterpart of the RAM-to-PC dump path. When armed, it receives bytes on rs232_rx and packs each group of 4 bytes into one 32-bit word, first byte in the low byte. It writes words to consecutive RAM addresses from startAddr through endAddr inclusive. It then pulses ok and sits between the PC link and the correlator's 32-bit sample/coefficient RAM write port.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; bit period BIT_CYC = CLK_HZ/BAUD (integer division; 868 at defaults)
TIMEOUT_CYC, 10000000, maximum idle cycles allowed between bytes once a transfer has started (100 ms at defaults)

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  reset, asynchronous, active-low
recvSig  input  1  one-cycle arm pulse; ignored unless FSM is in Swait
startAddr  input  16  first RAM address; sampled when recvSig is accepted
endAddr  input  16  last RAM address, inclusive; sampled when recvSig is accepted
rs232_rx  input  1  UART line, idle high, 8N1, LSB first
write  output  1  one-cycle RAM write strobe
addr  output  16  RAM address, valid whenever write=1
wdata  output  32  RAM write data, valid whenever write=1
busy  output  1  high from arm until return to Swait
ok  output  1  one-cycle pulse after the write to endAddr
err  output  1  one-cycle pulse on timeout or framing error; the transfer is aborted

Behaviour:
- Reset values: write=0, addr=0, wdata=0, busy=0, ok=0, err=0, state=Swait, timeout counter=0. Reset mid-transfer discards any partial word and performs no write.
- Sub-module uart_rx:
  - Synchronises rs232_rx with 2 flops.
  - Detects the falling start edge and re-checks the start bit at its mid-bit point; a high sample there is a glitch, so uart_rx returns to idle with no output.
  - Samples each data bit at mid-bit.
  - Checks the stop bit at mid-bit, then raises rx_int for 1 cycle with rx_data[7:0]. If the stop bit is 0 it raises frame_err instead.
- FSM states: Swait, Sarm, Srecv0, Srecv1, Srecv2, Srecv3, Swrite, SnextAddr, Send, Serr.
  - Swait: on recvSig, latch startAddr into addr and endAddr into an internal end register, then go to Sarm. busy=0 only in Swait.
  - Sarm: clear wdata and the timeout counter, go to Srecv0.
  - SrecvK (K=0..3): on rx_int, wdata[8K+7:8K] <= rx_data. Srecv0..2 advance to Srecv(K+1); Srecv3 advances to Swrite.
  - Swrite: write=1 for exactly this one cycle; addr and wdata are stable throughout. Next state is SnextAddr.
  - SnextAddr: if addr==end, go to Send with addr unchanged. Otherwise addr <= addr+1 (16-bit modulo, so 0xFFFF→0x0000) and go to Srecv0.
  - Send: ok=1 for one cycle, then Swait.
  - Serr: err=1 for one cycle, then Swait. No write occurs for the partial word.
- Latency: 4th byte rx_int at cycle N → write=1 at cycle N+1 → ok=1 at N+3 when that word was the last one.
- Timeout:
  - The counter is idle in Srecv0 of the first word; the PC may take arbitrarily long to start.
  - After the first rx_int of the transfer, the counter runs in every Srecv state and clears on each rx_int.
  - When it reaches TIMEOUT_CYC, go to Serr.
- frame_err in any Srecv state → Serr.
- Bytes arriving in Swait, Swrite, SnextAddr or Send are dropped. At 115200 baud the minimum gap between bytes is thousands of cycles, so no byte is lost during the transfer itself.
- startAddr > endAddr wraps through 0xFFFF. startAddr==endAddr transfers exactly 1 word; a full 65536-word transfer is not expressible.
- recvSig while busy=1 has no effect. Simultaneous recvSig and rx_int in Swait: arm happens and the byte is dropped.
- write, ok, err and busy are registered outputs (no combinational decode to ports).

Decomposition:
- Shared package/header: FSM state encodings; the BIT_CYC formula; the byte-lane order, byte k → bits [8k+7:8k], which is common with the RAM-to-PC sender.
- One sub-module, uart_rx (clk, rst_n, rs232_rx, rx_data[7:0], rx_int, frame_err), instantiated once. It is the counterpart of the existing uart_tx and parameterised by CLK_HZ/BAUD.

Test Plan:
1. startAddr=0x0010, endAddr=0x0011; send bytes 78 56 34 12 EF BE AD DE at 115200 → write at 0x0010 with 0x12345678, then at 0x0011 with 0xDEADBEEF; ok pulses once ~2 cycles after the second write; busy falls with ok.
2. startAddr=endAddr=0xFFFF, bytes 01 02 03 04 → exactly one write, addr=0xFFFF, wdata=0x04030201; ok=1, no second write.
3. startAddr=0xFFFE, endAddr=0x0001, 16 bytes → writes at FFFE, FFFF, 0000, 0001 in order; no write to 0x0002.
4. Arm, send 2 bytes, then hold the line idle → err pulses TIMEOUT_CYC cycles after the 2nd byte's rx_int; no write; busy=0; a subsequent recvSig starts cleanly.
5. Send a byte with stop bit 0 as the 3rd byte → err pulse, no write, FSM back in Swait. A 0.3-bit low glitch on the idle line → no rx_int.
6. Assert rst_n=0 after 5 of 8 bytes, release, re-arm with startAddr=0x0020 and send 4 bytes → all outputs at reset values during reset; the only write afterwards is at 0x0020 with the new word. A recvSig pulse mid-transfer → ignored; addr sequence unchanged.

Source files
------------

// File: rtl/recv_pc_to_ram32_pkg.sv
// Shared definitions for the PC-to-RAM loader: FSM encodings, bit timing, byte-lane order.
package recv_pc_to_ram32_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    S_WAIT,
    S_ARM,
    S_RECV0,
    S_RECV1,
    S_RECV2,
    S_RECV3,
    S_WRITE,
    S_NEXT_ADDR,
    S_END,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // UART bit period in clock cycles (integer division)
  function automatic int unsigned bit_cyc(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Byte k of a word occupies bits [8k+7:8k]; shared with the RAM-to-PC sender
  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] word,
                                                 input logic [1:0]        lane,
                                                 input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] w;
    w = word;
    w[{lane, 3'b000} +: BYTE_W] = b;
    return w;
  endfunction

endpackage

// File: rtl/recv_pc_to_ram32_uart_rx.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, start-glitch rejection, stop-bit check.
module recv_pc_to_ram32_uart_rx
  import recv_pc_to_ram32_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs232_rx,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_int,
  output logic              frame_err
);

  localparam int unsigned BIT_CYC  = bit_cyc(CLK_HZ, BAUD);
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);

  logic              rx_s1, rx_s2, rx_s3;
  rx_state_t         rx_state, rx_state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic              half_hit_c, bit_hit_c;

  assign half_hit_c = (cnt == CNT_W'(HALF_CYC - 1));
  assign bit_hit_c  = (cnt == CNT_W'(BIT_CYC - 1));

  // Line synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rs232_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  // Receiver next-state: a high line at start mid-bit is a glitch
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_s3 && !rx_s2) rx_state_nxt = RX_START;
      RX_START: if (half_hit_c) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit_c && (bit_idx == 3'd7)) rx_state_nxt = RX_STOP;
      RX_STOP:  if (bit_hit_c) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  // Bit counter, LSB-first shifter and registered byte/error strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_int    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_int    <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: cnt <= half_hit_c ? '0 : cnt + CNT_W'(1);
        RX_DATA: begin
          if (bit_hit_c) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[BYTE_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (bit_hit_c) begin
            cnt <= '0;
            if (rx_s2) begin
              rx_int  <= 1'b1;
              rx_data <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/recv_pc_to_ram32.sv
// UART-to-RAM loader: packs 4 received bytes per word and writes startAddr..endAddr.
module recv_pc_to_ram32
  import recv_pc_to_ram32_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              recvSig,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] endAddr,
  input  logic              rs232_rx,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ok,
  output logic              err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] end_addr;
  logic [TO_W-1:0]   to_cnt;
  logic              started;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_int, frame_err;
  logic              in_recv_c, to_hit_c;
  logic [1:0]        lane_c;
  logic              write_nxt_c, ok_nxt_c, err_nxt_c, busy_nxt_c;

  recv_pc_to_ram32_uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .frame_err (frame_err)
  );

  // Which byte lane the current receive state fills
  always_comb begin
    in_recv_c = 1'b1;
    lane_c    = 2'd0;
    case (state)
      S_RECV0: lane_c = 2'd0;
      S_RECV1: lane_c = 2'd1;
      S_RECV2: lane_c = 2'd2;
      S_RECV3: lane_c = 2'd3;
      default: in_recv_c = 1'b0;
    endcase
  end

  // Idle gap limit, only armed once the first byte of the transfer has arrived
  assign to_hit_c = in_recv_c && started && !rx_int && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:      if (recvSig) state_nxt = S_ARM;
      S_ARM:       state_nxt = S_RECV0;
      S_RECV0:     if (frame_err || to_hit_c) state_nxt = S_ERR;
                   else if (rx_int) state_nxt = S_RECV1;
      S_RECV1:     if (frame_err || to_hit_c) state_nxt = S_ERR;
                   else if (rx_int) state_nxt = S_RECV2;
      S_RECV2:     if (frame_err || to_hit_c) state_nxt = S_ERR;
                   else if (rx_int) state_nxt = S_RECV3;
      S_RECV3:     if (frame_err || to_hit_c) state_nxt = S_ERR;
                   else if (rx_int) state_nxt = S_WRITE;
      S_WRITE:     state_nxt = S_NEXT_ADDR;
      S_NEXT_ADDR: state_nxt = (addr == end_addr) ? S_END : S_RECV0;
      S_END:       state_nxt = S_WAIT;
      S_ERR:       state_nxt = S_WAIT;
      default:     state_nxt = S_WAIT;
    endcase
  end

  // Output decode from the upcoming state so the strobes line up with it once registered
  always_comb begin
    write_nxt_c = 1'b0;
    ok_nxt_c    = 1'b0;
    err_nxt_c   = 1'b0;
    busy_nxt_c  = 1'b0;
    write_nxt_c = (state_nxt == S_WRITE);
    ok_nxt_c    = (state_nxt == S_END);
    err_nxt_c   = (state_nxt == S_ERR);
    busy_nxt_c  = (state_nxt != S_WAIT);
  end

  // Registered strobes, address/word datapath and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write    <= 1'b0;
      ok       <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      end_addr <= '0;
      to_cnt   <= '0;
      started  <= 1'b0;
    end else begin
      write <= write_nxt_c;
      ok    <= ok_nxt_c;
      err   <= err_nxt_c;
      busy  <= busy_nxt_c;
      case (state)
        S_WAIT: begin
          if (recvSig) begin
            addr     <= startAddr;
            end_addr <= endAddr;
          end
        end
        S_ARM: begin
          wdata   <= '0;
          to_cnt  <= '0;
          started <= 1'b0;
        end
        S_NEXT_ADDR: if (addr != end_addr) addr <= addr + ADDR_W'(1);
        default: begin
          if (in_recv_c) begin
            if (rx_int) begin
              wdata   <= put_byte(wdata, lane_c, rx_data);
              started <= 1'b1;
              to_cnt  <= '0;
            end else if (started) begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recv_pc_to_ram32.sv
// Randomised bench for recv_pc_to_ram32 against a word-packing reference model.
`timescale 1ns/1ps
module tb_recv_pc_to_ram32;

  localparam int unsigned CLK_HZ      = 1_000_000;
  localparam int unsigned BAUD        = 100_000;
  localparam int unsigned BIT_CYC     = CLK_HZ / BAUD;
  localparam int unsigned TIMEOUT_CYC = 2000;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        recv_sig;
  logic [15:0] start_addr, end_addr;
  logic        rs232_rx;
  logic        write;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        busy, ok, err;

  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] tx_bytes[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0, ok_cnt = 0, err_cnt = 0, ok_cyc = 0, last_wr_cyc = 0;
  int   ok0 = 0, err0 = 0;
  logic ok_prev = 1'b0;
  logic busy_after_ok = 1'b1;

  always #5 clk = ~clk;

  recv_pc_to_ram32 #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .recvSig   (recv_sig),
    .startAddr (start_addr),
    .endAddr   (end_addr),
    .rs232_rx  (rs232_rx),
    .write     (write),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .ok        (ok),
    .err       (err)
  );

  // Observe RAM port and status pulses away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (write === 1'b1) begin
      wr_q.push_back({addr, wdata});
      last_wr_cyc = cyc;
    end
    if (ok === 1'b1) begin
      ok_cnt = ok_cnt + 1;
      ok_cyc = cyc;
    end
    if (err === 1'b1) err_cnt = err_cnt + 1;
    if (ok_prev) busy_after_ok = busy;
    ok_prev = (ok === 1'b1);
  end

  // Reference: word i goes to (start+i) mod 2^16, byte 4i+k in bits [8k+7:8k]
  function automatic void build_expected(input logic [15:0] s, input logic [15:0] e);
    int unsigned n;
    wr_t w;
    exp_q.delete();
    n = 32'(16'(e - s)) + 1;
    for (int unsigned i = 0; i < n; i++) begin
      w.a = 16'(32'(s) + i);
      w.d = {tx_bytes[4*i+3], tx_bytes[4*i+2], tx_bytes[4*i+1], tx_bytes[4*i]};
      exp_q.push_back(w);
    end
  endfunction

  task automatic prep();
    wr_q.delete();
    ok0  = ok_cnt;
    err0 = err_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rs232_rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rs232_rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    rs232_rx = 1'b1;
  endtask

  task automatic arm(input logic [15:0] s, input logic [15:0] e);
    start_addr = s;
    end_addr   = e;
    recv_sig   = 1'b1;
    @(negedge clk);
    recv_sig = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_transfer(input logic [15:0] s, input logic [15:0] e,
                             input int ignore_idx, input bit glitch);
    arm(s, e);
    if (glitch) begin
      rs232_rx = 1'b0;
      repeat (3) @(negedge clk);
      rs232_rx = 1'b1;
      repeat (30) @(negedge clk);
    end
    for (int i = 0; i < tx_bytes.size(); i++) begin
      send_byte(tx_bytes[i], 1'b1);
      repeat (4) @(negedge clk);
      if (i == ignore_idx) begin
        start_addr = 16'h1234;
        end_addr   = 16'h1234;
        recv_sig   = 1'b1;
        @(negedge clk);
        recv_sig = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({write, addr, wdata, busy, ok, err} !== 51'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got w=%b a=%h d=%h busy=%b ok=%b err=%b, want all 0",
               write, addr, wdata, busy, ok, err);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    tx_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    prep();
    do_transfer(16'h0010, 16'h0011, -1, 1'b0);
    build_expected(16'h0010, 16'h0011);
    n_cmp++;
    if (wr_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_count: got %0d writes, want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_write[%0d]: got %h/%h, want %h/%h", i, wr_q[i].a, wr_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    n_cmp++;
    if (ok_cnt - ok0 != 1) begin
      n_bad++;
      $display("FAIL basic_ok: got %0d pulses, want 1", ok_cnt - ok0);
    end
    n_cmp++;
    if (ok_cyc - last_wr_cyc != 2) begin
      n_bad++;
      $display("FAIL basic_ok_latency: got %0d cycles after write, want 2", ok_cyc - last_wr_cyc);
    end
    n_cmp++;
    if (busy_after_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy_fall: got busy=%b after ok, want 0", busy_after_ok);
    end
    n_cmp++;
    if (err_cnt != err0) begin
      n_bad++;
      $display("FAIL basic_err: got %0d err pulses, want 0", err_cnt - err0);
    end
  endtask

  task automatic test_single_ffff();
    tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    prep();
    do_transfer(16'hFFFF, 16'hFFFF, -1, 1'b0);
    build_expected(16'hFFFF, 16'hFFFF);
    n_cmp++;
    if (wr_q.size() != 1) begin
      n_bad++;
      $display("FAIL single_count: got %0d writes, want 1", wr_q.size());
    end
    if (wr_q.size() > 0) begin
      n_cmp++;
      if (wr_q[0] !== exp_q[0]) begin
        n_bad++;
        $display("FAIL single_write: got %h/%h, want %h/%h", wr_q[0].a, wr_q[0].d, exp_q[0].a, exp_q[0].d);
      end
    end
    n_cmp++;
    if (ok_cnt - ok0 != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ok: got ok=%0d busy=%b, want ok=1 busy=0", ok_cnt - ok0, busy);
    end
  endtask

  task automatic test_wrap_ignore();
    tx_bytes.delete();
    for (int i = 0; i < 16; i++) tx_bytes.push_back(8'($urandom));
    prep();
    do_transfer(16'hFFFE, 16'h0001, 6, 1'b0);
    build_expected(16'hFFFE, 16'h0001);
    n_cmp++;
    if (wr_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d writes, want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL wrap_write[%0d]: got %h/%h, want %h/%h", i, wr_q[i].a, wr_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    n_cmp++;
    if (ok_cnt - ok0 != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_ok: got ok=%0d busy=%b, want ok=1 busy=0", ok_cnt - ok0, busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] s, e;
    int nw;
    for (int it = 0; it < 4; it++) begin
      s  = 16'($urandom);
      nw = int'($urandom_range(1, 3));
      e  = 16'(32'(s) + 32'(nw - 1));
      tx_bytes.delete();
      for (int i = 0; i < 4 * nw; i++) tx_bytes.push_back(8'($urandom));
      prep();
      do_transfer(s, e, -1, 1'b0);
      build_expected(s, e);
      n_cmp++;
      if (wr_q.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL random%0d_count: got %0d writes, want %0d", it, wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        n_cmp++;
        if (wr_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL random%0d_write[%0d]: got %h/%h, want %h/%h", it, i, wr_q[i].a, wr_q[i].d, exp_q[i].a, exp_q[i].d);
        end
      end
      n_cmp++;
      if (ok_cnt - ok0 != 1 || err_cnt != err0) begin
        n_bad++;
        $display("FAIL random%0d_status: got ok=%0d err=%0d, want ok=1 err=0", it, ok_cnt - ok0, err_cnt - err0);
      end
    end
  endtask

  task automatic test_timeout();
    int waited;
    prep();
    arm(16'h0040, 16'h0041);
    send_byte(8'($urandom), 1'b1);
    repeat (4) @(negedge clk);
    send_byte(8'($urandom), 1'b1);
    waited = 0;
    while (waited < int'(TIMEOUT_CYC) + 100 && err !== 1'b1) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (waited < int'(TIMEOUT_CYC - BIT_CYC) || waited > int'(TIMEOUT_CYC + BIT_CYC)) begin
      n_bad++;
      $display("FAIL timeout_delay: got err after %0d cycles, want about %0d", waited, TIMEOUT_CYC);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 0 || busy !== 1'b0 || ok_cnt != ok0) begin
      n_bad++;
      $display("FAIL timeout_abort: got writes=%0d busy=%b ok=%0d, want 0/0/0", wr_q.size(), busy, ok_cnt - ok0);
    end
    tx_bytes.delete();
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom));
    prep();
    do_transfer(16'h0050, 16'h0050, -1, 1'b0);
    build_expected(16'h0050, 16'h0050);
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL timeout_rearm: got %0d writes first=%h, want 1 write %h/%h",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, exp_q[0].a, exp_q[0].d);
    end
  endtask

  task automatic test_frame_glitch();
    prep();
    arm(16'h0030, 16'h0031);
    send_byte(8'($urandom), 1'b1);
    repeat (4) @(negedge clk);
    send_byte(8'($urandom), 1'b1);
    repeat (4) @(negedge clk);
    send_byte(8'($urandom), 1'b0);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (err_cnt - err0 != 1) begin
      n_bad++;
      $display("FAIL frame_err: got %0d err pulses, want 1", err_cnt - err0);
    end
    n_cmp++;
    if (wr_q.size() != 0 || busy !== 1'b0 || ok_cnt != ok0) begin
      n_bad++;
      $display("FAIL frame_abort: got writes=%0d busy=%b ok=%0d, want 0/0/0", wr_q.size(), busy, ok_cnt - ok0);
    end
    tx_bytes.delete();
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom));
    prep();
    do_transfer(16'h0055, 16'h0055, -1, 1'b1);
    build_expected(16'h0055, 16'h0055);
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] !== exp_q[0] || err_cnt != err0) begin
      n_bad++;
      $display("FAIL glitch_reject: got %0d writes first=%h err=%0d, want 1 write %h/%h err=0",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, err_cnt - err0, exp_q[0].a, exp_q[0].d);
    end
  endtask

  task automatic test_reset_midflight();
    arm(16'h0100, 16'h0101);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom), 1'b1);
      repeat (4) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({write, addr, wdata, busy, ok, err} !== 51'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got w=%b a=%h d=%h busy=%b ok=%b err=%b, want all 0",
               write, addr, wdata, busy, ok, err);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_bytes.delete();
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom));
    prep();
    do_transfer(16'h0020, 16'h0020, -1, 1'b0);
    build_expected(16'h0020, 16'h0020);
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] !== exp_q[0] || err_cnt != err0) begin
      n_bad++;
      $display("FAIL midreset_rearm: got %0d writes first=%h err=%0d, want 1 write %h/%h err=0",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, err_cnt - err0, exp_q[0].a, exp_q[0].d);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    recv_sig   = 1'b0;
    start_addr = 16'h0000;
    end_addr   = 16'h0000;
    rs232_rx   = 1'b1;
    test_reset();
    test_basic();
    test_single_ffff();
    test_wrap_ignore();
    test_random();
    test_timeout();
    test_frame_glitch();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
